// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// Arbitration mode is selected in the top and selector by DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef logic mst_id_t;

    localparam mst_id_t MST0 = 1'b0;
    localparam mst_id_t MST1 = 1'b1;

    localparam int DEF_MAX_BURST    = 8;
    localparam int DEF_STARVE_LIMIT = 16;

endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational winner selection for the two dmem masters.
// DMEM_ARB_RR_EN selects round-robin ties; otherwise fixed priority with starvation escape.
module dmem_arb_sel
    import dmem_arb_pkg::*;
(
    input  logic    m0_req,
    input  logic    m1_req,
    input  logic    lock_hold,
    input  mst_id_t owner,
    input  logic    burst_done,
`ifdef DMEM_ARB_RR_EN
    input  mst_id_t last_gnt,
`else
    input  logic    starve_hit,
`endif
    output logic    gnt_vld,
    output mst_id_t gnt_id
);

    logic other_req;
    logic tie_m1;

    always_comb begin
        other_req = (owner == MST0) ? m1_req : m0_req;
`ifdef DMEM_ARB_RR_EN
        tie_m1    = (last_gnt == MST0);
`else
        tie_m1    = starve_hit;
`endif
        gnt_vld   = m0_req | m1_req;
        gnt_id    = MST0;
        // A locked owner keeps the port unless its burst quota ran out while the other waits.
        if (lock_hold) begin
            gnt_id = (burst_done && other_req) ? ~owner : owner;
        end else if (m0_req && m1_req) begin
            gnt_id = tie_m1 ? MST1 : MST0;
        end else if (m1_req) begin
            gnt_id = MST1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory with locked bursts and 1-cycle read return.
// Define DMEM_ARB_RR_EN for round-robin ties; default is M0 priority with an M1 starvation escape.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] OWN0 = ST_OWN0;
    localparam logic [1:0] OWN1 = ST_OWN1;

    localparam int            BW       = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

    logic [1:0]    state;
    logic          lock_r;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_next;
    logic          resp_vld_p1;
    mst_id_t       resp_id_p1;

    mst_id_t       owner;
    logic          lock_hold;
    logic          gnt_vld;
    mst_id_t       gnt_id;
    logic          gnt_lock;

`ifdef DMEM_ARB_RR_EN
    mst_id_t       last_gnt;
`else
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;
`endif

    assign owner     = (state == OWN1) ? MST1 : MST0;
    assign lock_hold = lock_r && (state != IDLE) && ((owner == MST1) ? m1_req : m0_req);

    dmem_arb_sel u_sel (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .lock_hold  (lock_hold),
        .owner      (owner),
        .burst_done (beat_cnt == BEAT_MAX),
`ifdef DMEM_ARB_RR_EN
        .last_gnt   (last_gnt),
`else
        .starve_hit (starve_cnt == STARVE_MAX),
`endif
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    // Grant and memory-side mux: zero when nobody owns the port this cycle.
    always_comb begin
        m0_gnt    = gnt_vld && (gnt_id == MST0);
        m1_gnt    = gnt_vld && (gnt_id == MST1);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        gnt_lock  = 1'b0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            gnt_lock  = m0_lock;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            gnt_lock  = m1_lock;
        end
    end

    // The first locked beat of a burst counts as one; held beats extend it up to the quota.
    always_comb begin
        beat_next = '0;
        if (gnt_vld && gnt_lock) begin
            if (lock_hold && (gnt_id == owner)) begin
                beat_next = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 1'b1;
            end else begin
                beat_next = BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lock_r      <= 1'b0;
            beat_cnt    <= '0;
            resp_vld_p1 <= 1'b0;
            resp_id_p1  <= MST0;
`ifdef DMEM_ARB_RR_EN
            last_gnt    <= MST1;
`else
            starve_cnt  <= '0;
`endif
        end else begin
            state       <= !gnt_vld ? IDLE : ((gnt_id == MST1) ? OWN1 : OWN0);
            lock_r      <= gnt_vld && gnt_lock;
            beat_cnt    <= beat_next;
            // stage p1: read response is tagged with the master granted in p0
            resp_vld_p1 <= gnt_vld && !mem_we;
            resp_id_p1  <= gnt_id;
`ifdef DMEM_ARB_RR_EN
            if (gnt_vld) begin
                last_gnt <= gnt_id;
            end
`else
            if (m1_gnt) begin
                starve_cnt <= '0;
            end else if (m1_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
`endif
        end
    end

    assign m0_rvalid = resp_vld_p1 && (resp_id_p1 == MST0);
    assign m1_rvalid = resp_vld_p1 && (resp_id_p1 == MST1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs. a reference model.
// Honours DMEM_ARB_RR_EN for the expected arbitration mode.
module tb_dmem_arbiter;

    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW(32), .DW(32), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory stand-in: one-cycle read latency, write commits at the edge.
    logic [31:0] dmem [64];
    always @(posedge clk) begin
        mem_rdata <= dmem[mem_addr[7:2]];
        if (mem_we) dmem[mem_addr[7:2]] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether it is locked, burst length, M1 wait time.
    int          mo_owner = -1;
    bit          mo_locked = 0;
    int          mo_run = 0;
    int          mo_wait1 = 0;
    int          mo_last = 1;
    bit          pend_rv [2];
    logic [31:0] pend_rd;
    logic [31:0] gold [64];
    int          gq [$];

    always @(negedge clk) begin
        int          w;
        bit [1:0]    rq;
        bit          held, lk;
        logic        ew;
        logic [31:0] ea, ed;
        if (rst) begin
            chk("reset_outputs",
                {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, |mem_addr, |mem_wdata, |m0_rdata, |m1_rdata},
                64'h0);
            mo_owner = -1; mo_locked = 0; mo_run = 0; mo_wait1 = 0; mo_last = 1;
            pend_rv[0] = 0; pend_rv[1] = 0;
        end else begin
            rq   = {m1_req, m0_req};
            held = (mo_owner >= 0) && mo_locked && rq[mo_owner];
            w    = -1;
            if (rq != 2'b00) begin
                if (held) begin
                    w = (mo_run >= MAX_BURST && rq[1 - mo_owner]) ? 1 - mo_owner : mo_owner;
                end else if (rq == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                    w = 1 - mo_last;
`else
                    w = (mo_wait1 >= STARVE_LIMIT) ? 1 : 0;
`endif
                end else begin
                    w = rq[0] ? 0 : 1;
                end
            end
            ew = 1'b0; ea = 32'h0; ed = 32'h0; lk = 1'b0;
            if (w == 0) begin ew = m0_we; ea = m0_addr; ed = m0_wdata; lk = m0_lock; end
            if (w == 1) begin ew = m1_we; ea = m1_addr; ed = m1_wdata; lk = m1_lock; end

            chk("m0_gnt", m0_gnt, w == 0);
            chk("m1_gnt", m1_gnt, w == 1);
            chk("mem_we", mem_we, ew);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            chk("m0_rvalid", m0_rvalid, pend_rv[0]);
            chk("m1_rvalid", m1_rvalid, pend_rv[1]);
            chk("m0_rdata", m0_rdata, pend_rv[0] ? pend_rd : 32'h0);
            chk("m1_rdata", m1_rdata, pend_rv[1] ? pend_rd : 32'h0);

            pend_rv[0] = (w == 0) && !ew;
            pend_rv[1] = (w == 1) && !ew;
            if (w >= 0) begin
                pend_rd = gold[ea[7:2]];
                if (ew) gold[ea[7:2]] = ed;
                if (!lk) mo_run = 0;
                else if (held && w == mo_owner) mo_run = mo_run + 1;
                else mo_run = 1;
                mo_owner = w; mo_locked = lk; mo_last = w;
            end else begin
                mo_owner = -1; mo_locked = 0; mo_run = 0;
            end
            if (w == 1) mo_wait1 = 0;
            else if (rq[1] && mo_wait1 < STARVE_LIMIT) mo_wait1 = mo_wait1 + 1;
            gq.push_back(w);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  m1_grants, cyc, n1;
        bit  m0_done, h0, h1;
        logic [31:0] v;

        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            dmem[i] = v;
            gold[i] = v;
        end
        dmem[4] = 32'hDEADBEEF;
        gold[4] = 32'hDEADBEEF;

        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("post_reset_idle", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we}, 64'h0);

        // Both masters request continuously without lock.
        gq.delete();
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h40; m1_addr = 32'h44;
        repeat (15) step();
        m0_req = 0; m1_req = 0;
        chk("both_len", gq.size(), 15);
        if (gq.size() >= 15) begin
            for (int i = 0; i < 15; i++) begin
`ifdef DMEM_ARB_RR_EN
                chk($sformatf("rr_pattern_%0d", i), gq[i], i % 2);
`else
                chk($sformatf("starve_pattern_%0d", i), gq[i], (i % 5 == 4) ? 1 : 0);
`endif
            end
        end
        step();

        // Single M0 read with one-cycle return.
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        #1;
        chk("t1_gnt", {m0_gnt, m1_gnt}, 64'b10);
        step();
        m0_req = 0;
        #1;
        chk("t1_rvalid", {m0_rvalid, m1_rvalid}, 64'b10);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        step();

        // M1 locked burst of 20 beats, M0 asks once.
        gq.delete();
        m1_req = 1; m1_lock = 1; m1_we = 1;
        m1_grants = 0; m0_done = 0; cyc = 0;
        m0_we = 0; m0_addr = 32'h08;
        while (m1_grants < 20 && cyc < 60) begin
            m0_req = (cyc >= 1) && !m0_done;
            m1_addr = rand_addr(); m1_wdata = $urandom;
            #1;
            if (m1_gnt) m1_grants++;
            if (m0_gnt) m0_done = 1;
            step();
            cyc++;
        end
        m0_req = 0; m1_req = 0; m1_lock = 0; m1_we = 0;
        chk("lock_finished", cyc < 60, 1);
        chk("lock_m0_served", m0_done, 1);
        if (gq.size() >= 10) begin
            n1 = 0;
            for (int i = 0; i < 8; i++) if (gq[i] == 1) n1++;
            chk("lock_first8_m1", n1, 8);
            chk("lock_beat9_m0", gq[8], 0);
            chk("lock_beat10_m1", gq[9], 1);
        end else begin
            chk("lock_trace_len", gq.size(), 10);
        end
        step();

        // M0 write followed by read of the same address.
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h55;
        #1;
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h20);
        step();
        m0_we = 0;
        #1;
        chk("rd_mem_we", mem_we, 0);
        step();
        m0_req = 0;
        #1;
        chk("rd_rvalid", m0_rvalid, 1);
        chk("rd_data", m0_rdata, 32'h55);
        step();

        // Async reset while an M1 read response is in flight.
        m1_req = 1; m1_we = 0; m1_addr = 32'h30;
        #1;
        chk("rst_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        #1;
        m1_req = 0;
        rst = 1'b1;
        #1;
        chk("rst_async_zero", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, |m1_rdata}, 64'h0);
        step();
        chk("rst_m1_rvalid_a", m1_rvalid, 0);
        step();
        chk("rst_m1_rvalid_b", m1_rvalid, 0);
        rst = 1'b0;
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        #1;
        chk("post_rst_arb", {m0_gnt, m1_gnt}, 64'b10);
        step();
        m0_req = 0; m1_req = 0;
        #1;
        chk("post_rst_m1_rvalid", m1_rvalid, 0);
        step();

        // Randomized traffic; requests held until granted.
        h0 = 0; h1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                rst = 1'b1; m0_req = 0; m1_req = 0; h0 = 0; h1 = 0;
                step(); step();
                rst = 1'b0;
            end
            if (!h0) begin
                m0_req = ($urandom_range(0, 2) != 0); m0_we = $urandom_range(0, 1);
                m0_addr = rand_addr(); m0_wdata = $urandom;
            end
            if (!h1) begin
                m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1);
                m1_addr = rand_addr(); m1_wdata = $urandom;
            end
            m0_lock = ($urandom_range(0, 3) != 0);
            m1_lock = ($urandom_range(0, 3) != 0);
            #1;
            h0 = m0_req && !m0_gnt;
            h1 = m1_req && !m1_gnt;
            step();
        end
        m0_req = 0; m1_req = 0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the pipeline's data port (M0) and a secondary master such as a debug loader or DMA engine (M1). It sits between the core and `dmem` in the SoC top. Each cycle it grants at most one access, holds ownership for locked bursts, and prevents starvation. Read responses are returned to the granted master one cycle later.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_BURST`, 8, maximum consecutive locked grants to one master while the other is waiting (≥1)
- `STARVE_LIMIT`, 16, wait cycles after which a waiting M1 is force-granted (fixed-priority mode only, ≥1)

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_lock`, `m1_lock`  in  1  request to keep ownership on the next beat
- `m0_addr`, `m1_addr`  in  AW  byte address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered)
- `m0_rdata`, `m1_rdata`  out  DW  read data
- `mem_we`  out  1  to `dmem` write enable
- `mem_addr`  out  AW  to `dmem`
- `mem_wdata`  out  DW  to `dmem`
- `mem_rdata`  in  DW  from `dmem`; valid the cycle after the address is presented

## Operation
- A grant means the request is driven onto `mem_*` in that same cycle. A write commits at the next rising edge. For a read, the matching `mN_rvalid` is asserted the following cycle with `mN_rdata = mem_rdata`.
- At most one `gnt` is asserted per cycle. With no grant, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- FSM states: IDLE, OWN0, OWN1. The state records the current owner.
  - IDLE to OWNn: a grant is issued to Mn.
  - OWNn to IDLE: neither master is requesting.
  - OWNn to OWNm: rearbitration selects the other master.
- Lock:
  - If the owner was granted with `lock=1` and still requests, it is granted again without arbitration.
  - `beat_cnt` counts consecutive locked grants.
  - Once `beat_cnt == MAX_BURST` and the other master is requesting, lock is ignored for one cycle and the other master is granted.
  - `beat_cnt` clears on an owner change or when the owner's `req` drops.
- Unlocked arbitration (default mode):
  - A lone requester is granted.
  - If both request, M0 wins, unless `starve_cnt == STARVE_LIMIT`, in which case M1 wins.
  - `starve_cnt` increments each cycle M1 requests without a grant. It saturates at `STARVE_LIMIT` and clears when M1 is granted.
- Read-response routing: the registered `resp_id` and `rvalid` are stored at grant time. `mN_rdata` is 0 when `mN_rvalid` is 0.

## Timing
- Grant: 0-cycle combinational from `req` (and registered state) to `gnt` and `mem_*`.
- Read latency: `rvalid` and `rdata` arrive exactly 1 cycle after the grant. Back-to-back reads are permitted, one per cycle.
- Owner switch costs no bubble; the new owner is granted in the cycle of rearbitration.
- Reset values:
  - State = IDLE; `beat_cnt`, `starve_cnt` = 0; `last_gnt` = M1.
  - All `gnt` and `rvalid` = 0; all `rdata` = 0; `mem_*` = 0.
- Reset asserted mid-access clears `rvalid` immediately; the pending read response is dropped.
- If `req` is deasserted while an `rvalid` is outstanding, the response is still delivered.
- A simultaneous lock expiry and starvation limit both select M1; only one grant is issued.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Unlocked arbitration is round-robin; when both request, the master not equal to `last_gnt` wins.
  - `starve_cnt` and `STARVE_LIMIT` are compiled out.
- Undefined: fixed priority for M0 with the M1 starvation escape described above.

## Structure
- Package `dmem_arb_pkg` holds:
  - the owner/state enum (IDLE, OWN0, OWN1);
  - the master-ID type;
  - default constants for `MAX_BURST` and `STARVE_LIMIT`.
- One natural sub-module, `dmem_arb_sel`: purely combinational winner selection from the requests, lock status, `beat_cnt` limit, and either `starve_cnt` or `last_gnt`.
- The FSM, counters and response registers stay in the top module.

## Test plan
- M0 only, read at `0x10`, `mem_rdata = 0xDEADBEEF` → `m0_gnt=1` in cycle 0; `m0_rvalid=1` with `m0_rdata=0xDEADBEEF` in cycle 1; `m1_rvalid` stays 0.
- Both request continuously with no lock, fixed mode, `STARVE_LIMIT=4` → M0 granted for 4 cycles, M1 granted in cycle 5, then the pattern repeats.
- Same stimulus with `DMEM_ARB_RR_EN` → grants alternate M0, M1, M0, … starting with M0.
- M1 holds `lock=1` for 20 beats, M0 requesting, `MAX_BURST=8` → M1 gets 8 grants, M0 gets 1, then M1 resumes.
- M0 issues a write of `0x55` to `0x20`, then reads `0x20` in the next cycle → `mem_we` is 1 for one cycle; the read returns `0x55`.
- `rst` asserted asynchronously one cycle after an M1 read grant → `m1_rvalid` never asserts; all outputs are 0 and the state is IDLE after reset.
